// File: rtl/mips_prog_sequencer.sv
// Boot/run sequencer for mips_core. It streams a host program into instruction memory,
// zero-fills the rest, runs the core until pc falls off the program end or the budget expires.
module mips_prog_sequencer #(
  parameter int PC_WIDTH       = 32,
  parameter int INSTR_WIDTH    = 32,
  parameter int IMEM_DEPTH     = 256,
  parameter int ADDR_W         = $clog2(IMEM_DEPTH),
  parameter int MAX_RUN_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_start,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   load_last,
  input  logic                   abort,
  output logic                   imem_we,
  output logic [ADDR_W-1:0]      imem_waddr,
  output logic [INSTR_WIDTH-1:0] imem_wdata,
  input  logic [PC_WIDTH-1:0]    core_pc,
  output logic                   core_rst_n,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  output logic                   overflow,
  output logic [ADDR_W:0]        word_count,
  output logic [31:0]            cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FILL,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);
  localparam logic [31:0]       MAX_CC    = 32'(MAX_RUN_CYCLES);

  state_t              state_reg;
  logic [ADDR_W-1:0]   fill_addr_reg;
  logic                handshake;
  logic                at_last_addr;
  logic [PC_WIDTH-1:0] end_pc;

  assign load_ready   = (state_reg == S_LOAD) & ~abort;
  assign handshake    = load_valid & load_ready;
  assign busy         = (state_reg == S_LOAD) | (state_reg == S_FILL) | (state_reg == S_RUN);
  assign done         = (state_reg == S_DONE);
  // While loading, word_count never exceeds DEPTH-1, so its low bits are the write address.
  assign at_last_addr = (word_count[ADDR_W-1:0] == LAST_ADDR);
  assign end_pc       = PC_WIDTH'({word_count, 2'b00});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      fill_addr_reg <= '0;
      imem_we       <= 1'b0;
      imem_waddr    <= '0;
      imem_wdata    <= '0;
      core_rst_n    <= 1'b0;
      timeout       <= 1'b0;
      overflow      <= 1'b0;
      word_count    <= '0;
      cycle_count   <= '0;
    end else if (abort) begin
      state_reg  <= S_IDLE;
      imem_we    <= 1'b0;
      core_rst_n <= 1'b0;
    end else begin
      imem_we    <= 1'b0;
      core_rst_n <= 1'b0;
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (load_start) begin
            state_reg   <= S_LOAD;
            word_count  <= '0;
            cycle_count <= '0;
            timeout     <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        S_LOAD: begin
          if (handshake) begin
            imem_we    <= 1'b1;
            imem_waddr <= word_count[ADDR_W-1:0];
            imem_wdata <= load_data;
            word_count <= word_count + (ADDR_W + 1)'(1);
            if (load_last || at_last_addr) begin
              if (!load_last) overflow <= 1'b1;
              // A completely full memory has nothing left to zero-fill.
              if (at_last_addr) begin
                state_reg  <= S_RUN;
                core_rst_n <= 1'b1;
              end else begin
                state_reg     <= S_FILL;
                fill_addr_reg <= word_count[ADDR_W-1:0] + 1'b1;
              end
            end
          end
        end
        S_FILL: begin
          imem_we       <= 1'b1;
          imem_waddr    <= fill_addr_reg;
          imem_wdata    <= '0;
          fill_addr_reg <= fill_addr_reg + 1'b1;
          if (fill_addr_reg == LAST_ADDR) begin
            state_reg  <= S_RUN;
            core_rst_n <= 1'b1;
          end
        end
        S_RUN: begin
          if (cycle_count != MAX_CC) cycle_count <= cycle_count + 32'd1;
          // Budget expiry wins over a simultaneous program-end match.
          if (cycle_count == MAX_CC - 32'd1) begin
            timeout   <= 1'b1;
            state_reg <= S_DONE;
          end else if (core_pc == end_pc) begin
            state_reg <= S_DONE;
          end else begin
            core_rst_n <= 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_prog_sequencer.sv
// Directed bench for mips_prog_sequencer: table of load/run scenarios plus abort and
// asynchronous-reset sequences. A tiny pc model stands in for mips_core.
module tb_mips_prog_sequencer;

  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int MAXC  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [31:0]   load_data = '0;
  logic          load_last = 1'b0;
  logic          abort = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic [31:0]   core_pc = '0;
  logic          core_rst_n;
  logic          busy;
  logic          done;
  logic          timeout;
  logic          overflow;
  logic [AW:0]   word_count;
  logic [31:0]   cycle_count;

  mips_prog_sequencer #(
    .PC_WIDTH(32), .INSTR_WIDTH(32), .IMEM_DEPTH(DEPTH), .ADDR_W(AW), .MAX_RUN_CYCLES(MAXC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_valid(load_valid),
    .load_ready(load_ready), .load_data(load_data), .load_last(load_last), .abort(abort),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .core_pc(core_pc),
    .core_rst_n(core_rst_n), .busy(busy), .done(done), .timeout(timeout),
    .overflow(overflow), .word_count(word_count), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Core stand-in: straight-line code advances pc by 4; jmode models "j 0" (pc stuck at 0).
  logic jmode = 1'b0;
  always @(posedge clk) begin
    if (!core_rst_n) core_pc <= '0;
    else if (!jmode) core_pc <= core_pc + 32'd4;
  end

  logic [AW-1:0] log_addr[$];
  logic [31:0]   log_data[$];
  always @(negedge clk) begin
    if (imem_we) begin
      log_addr.push_back(imem_waddr);
      log_data.push_back(imem_wdata);
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input int i, input bit jm);
    if (jm && i == 0) return 32'h0800_0000;
    case (i)
      0:       return 32'h2008_0005;
      1:       return 32'h2009_0007;
      2:       return 32'h0109_5020;
      default: return 32'hA500_0000 | 32'(i);
    endcase
  endfunction

  typedef struct {
    int         n;
    logic [4:0] pat;
    bit         last;
    bit         jm;
    int         exp_wc;
    bit         exp_to;
    bit         exp_ov;
    int         exp_cc;
  } vec_t;

  vec_t tbl[8];

  task automatic do_load(input vec_t v, input string tag);
    int i = 0;
    int cyc = 0;
    bit acc = 1'b0;
    bit acc_prev = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [31:0] e_data = '0;
    log_addr.delete();
    log_data.delete();
    jmode = v.jm;
    @(posedge clk); #1 load_start = 1'b1;
    @(posedge clk); #1 load_start = 1'b0;
    chk({tag, "_wc_clear"}, word_count, 0);
    chk({tag, "_flags_clear"}, {timeout, overflow}, 0);
    while (i < v.n) begin
      load_valid = v.pat[cyc % 5];
      load_data  = word(i, v.jm);
      load_last  = v.last && (i == v.n - 1);
      @(negedge clk);
      chk({tag, "_ready"}, load_ready, 1);
      if (acc_prev) chk({tag, "_write"}, {imem_we, imem_waddr, imem_wdata}, {1'b1, e_addr, e_data});
      else          chk({tag, "_nowrite"}, imem_we, 0);
      acc = load_valid && load_ready;
      @(posedge clk); #1;
      acc_prev = acc;
      if (acc) begin
        e_addr = AW'(i);
        e_data = word(i, v.jm);
        i++;
      end
      cyc++;
      if (cyc > 2000) begin
        chk({tag, "_load_bound"}, 0, 1);
        break;
      end
    end
    load_last  = 1'b0;
    load_valid = (v.n == DEPTH);
    load_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    chk({tag, "_lastwrite"}, {imem_we, imem_waddr, imem_wdata}, {1'b1, e_addr, e_data});
    if (v.n == DEPTH) chk({tag, "_ready_full"}, load_ready, 0);
    @(posedge clk); #1 load_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int k = 0;
    int bad = 0;
    do_load(v, tag);
    while (!done && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_wc"}, word_count, v.exp_wc);
    chk({tag, "_timeout"}, timeout, v.exp_to);
    chk({tag, "_overflow"}, overflow, v.exp_ov);
    chk({tag, "_cycles"}, cycle_count, v.exp_cc);
    chk({tag, "_core_rst"}, {core_rst_n, busy}, 0);
    chk({tag, "_nwrites"}, log_addr.size(), DEPTH);
    for (int j = 0; j < log_addr.size(); j++) begin
      if (log_addr[j] !== AW'(j)) bad++;
      if (log_data[j] !== ((j < v.exp_wc) ? word(j, v.jm) : 32'h0)) bad++;
    end
    chk({tag, "_contents"}, bad, 0);
  endtask

  initial begin
    int k;
    tbl[0] = '{3,   5'b11111, 1'b1, 1'b0, 3,   1'b0, 1'b0, 4};
    tbl[1] = '{256, 5'b11111, 1'b0, 1'b0, 256, 1'b1, 1'b1, 16};
    tbl[2] = '{3,   5'b11001, 1'b1, 1'b0, 3,   1'b0, 1'b0, 4};
    tbl[3] = '{1,   5'b11111, 1'b1, 1'b1, 1,   1'b1, 1'b0, 16};
    tbl[4] = '{15,  5'b11111, 1'b1, 1'b0, 15,  1'b1, 1'b0, 16};
    tbl[5] = '{14,  5'b10101, 1'b1, 1'b0, 14,  1'b0, 1'b0, 15};
    tbl[6] = '{256, 5'b11111, 1'b1, 1'b0, 256, 1'b1, 1'b0, 16};
    tbl[7] = '{255, 5'b11111, 1'b1, 1'b0, 255, 1'b1, 1'b0, 16};

    @(negedge clk);
    chk("reset_outputs", {core_rst_n, busy, done, timeout, overflow, imem_we, load_ready}, 0);
    chk("reset_counts", {word_count, cycle_count}, 0);
    rst_n = 1'b1;

    for (int t = 0; t < 8; t++) run_vec(tbl[t], $sformatf("vec%0d", t));

    // Abort in the middle of the zero-fill, then restart a fresh load.
    do_load(tbl[0], "abort");
    k = 0;
    while (!(imem_we && imem_waddr == AW'(100)) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("abort_reach_fill100", {imem_we, imem_waddr}, {1'b1, AW'(100)});
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_idle", {busy, done, core_rst_n, imem_we, load_ready}, 0);
    chk("abort_hold_wc", word_count, 3);
    repeat (5) @(negedge clk);
    chk("abort_no_more_writes", log_addr.size(), 101);
    run_vec(tbl[0], "after_abort");

    // load_start ignored in RUN, then asynchronous reset mid-run.
    do_load(tbl[3], "rstrun");
    k = 0;
    while (!core_rst_n && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("rstrun_in_run", {core_rst_n, busy}, 2'b11);
    load_start = 1'b1;
    @(posedge clk); #1 load_start = 1'b0;
    @(negedge clk);
    chk("run_ignores_start", {word_count, busy, core_rst_n}, {9'd1, 1'b1, 1'b1});
    chk("run_cycles_kept", (cycle_count != 0), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_flags", {core_rst_n, busy, done, timeout, overflow, imem_we, load_ready}, 0);
    chk("async_rst_counts", {word_count, cycle_count}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
